// File: rtl/move_step_scheduler.sv
// move_step_scheduler: paces two players' held directions into ticked steps on one shared valid/ready port.
// Define MOVE_SCHED_DIAGONAL_EN to allow one vertical plus one horizontal bit in a step.
module move_step_scheduler #(
  parameter int unsigned TICK_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] p0_dir,
  input  logic [3:0] p1_dir,
  input  logic       ovr_clr,
  output logic       step_valid,
  input  logic       step_ready,
  output logic       step_player,
  output logic [3:0] step_dir,
  output logic [1:0] overrun
);
  typedef enum logic {IDLE, OFFER} state_t;
  localparam logic [15:0] LAST = 16'(TICK_CYCLES - 1);

  function automatic logic [3:0] resolve(input logic [3:0] d);
    logic [3:0] m;
    m = {(d[3] & d[2]) ? 2'b00 : d[3:2], (d[1] & d[0]) ? 2'b00 : d[1:0]};
`ifdef MOVE_SCHED_DIAGONAL_EN
    return m;
`else
    return m[3] ? 4'b1000 : m[2] ? 4'b0100 : m[1] ? 4'b0010 : m[0] ? 4'b0001 : 4'b0000;
`endif
  endfunction

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [1:0]      pend_q, pend_d;
  logic [1:0][3:0] pend_dir_q, pend_dir_d;
  logic            last_q, last_d;
  logic            player_q, player_d;
  logic [3:0]      dir_q, dir_d;
  logic [1:0]      ovr_q, ovr_d, ovr_set;
  logic [1:0][3:0] res;
  logic            tick, grant_v, g;

  assign tick   = cnt_q == LAST;
  assign cnt_d  = tick ? 16'd0 : cnt_q + 16'd1;
  assign res[0] = resolve(p0_dir);
  assign res[1] = resolve(p1_dir);

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    last_d     = last_q;
    player_d   = player_q;
    dir_d      = dir_q;
    grant_v    = 1'b0;
    g          = 1'b0;
    ovr_set    = 2'b00;
    if (state_q == IDLE && |pend_q) begin
      grant_v   = 1'b1;
      g         = &pend_q ? ~last_q : pend_q[1];
      player_d  = g;
      dir_d     = pend_dir_q[g];
      pend_d[g] = 1'b0;
      last_d    = g;
      state_d   = OFFER;
    end else if (state_q == OFFER && step_ready) begin
      state_d = IDLE;
    end
    // A slot being granted this cycle has already left, so refilling it is not an overrun.
    for (int p = 0; p < 2; p++) begin
      if (tick && |res[p]) begin
        ovr_set[p]    = pend_q[p] && !(grant_v && g == p[0]);
        pend_d[p]     = 1'b1;
        pend_dir_d[p] = res[p];
      end
    end
    ovr_d = (ovr_q & ~{2{ovr_clr}}) | ovr_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_dir_q <= '0;
      last_q     <= 1'b1;
      player_q   <= 1'b0;
      dir_q      <= '0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_dir_q <= pend_dir_d;
      last_q     <= last_d;
      player_q   <= player_d;
      dir_q      <= dir_d;
      ovr_q      <= ovr_d;
    end
  end

  assign step_valid  = state_q == OFFER;
  assign step_player = player_q;
  assign step_dir    = dir_q;
  assign overrun     = ovr_q;
endmodule

// File: tb/tb_move_step_scheduler.sv
// tb_move_step_scheduler: directed checks of pacing, arbitration, resolution, overrun and reset at TICK_CYCLES=8.
module tb_move_step_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] p0_dir = '0;
  logic [3:0] p1_dir = '0;
  logic       ovr_clr = 1'b0;
  logic       step_ready = 1'b0;
  logic       step_valid;
  logic       step_player;
  logic [3:0] step_dir;
  logic [1:0] overrun;
  int tests = 0;
  int fails = 0;

  move_step_scheduler #(.TICK_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .p0_dir(p0_dir), .p1_dir(p1_dir), .ovr_clr(ovr_clr),
    .step_valid(step_valid), .step_ready(step_ready), .step_player(step_player),
    .step_dir(step_dir), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    p0_dir = 4'b0000; p1_dir = 4'b0000; step_ready = 1'b1;
    do_reset;
    tests++; if (step_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", step_valid); end
    tests++; if (step_player !== 1'b0) begin fails++; $display("FAIL reset_player got %b exp 0", step_player); end
    tests++; if (step_dir !== 4'b0000) begin fails++; $display("FAIL reset_dir got %b exp 0000", step_dir); end
    tests++; if (overrun !== 2'b00) begin fails++; $display("FAIL reset_overrun got %b exp 00", overrun); end
  endtask

  task automatic test_single;
    logic ev;
    p0_dir = 4'b1000; p1_dir = 4'b0000; step_ready = 1'b1;
    do_reset;
    for (int k = 1; k <= 24; k++) begin
      step;
      ev = (k >= 9) && (k % 8 == 1);
      tests++; if (step_valid !== ev) begin fails++; $display("FAIL single_valid cyc %0d got %b exp %b", k, step_valid, ev); end
      if (ev) begin
        tests++; if ({step_player, step_dir} !== 5'b0_1000) begin fails++; $display("FAIL single_step cyc %0d got %b/%b exp 0/1000", k, step_player, step_dir); end
      end
    end
  endtask

  task automatic test_contention;
    logic ev, ep;
    p0_dir = 4'b0010; p1_dir = 4'b0100; step_ready = 1'b1;
    do_reset;
    for (int k = 1; k <= 24; k++) begin
      step;
      ev = (k == 9) || (k == 11) || (k == 17) || (k == 19);
      ep = (k == 11) || (k == 19);
      tests++; if (step_valid !== ev) begin fails++; $display("FAIL contention_valid cyc %0d got %b exp %b", k, step_valid, ev); end
      if (ev) begin
        tests++; if ({step_player, step_dir} !== {ep, ep ? 4'b0100 : 4'b0010}) begin fails++; $display("FAIL contention_step cyc %0d got %b/%b exp player %b", k, step_player, step_dir, ep); end
      end
    end
  endtask

  task automatic test_cancel;
    p0_dir = 4'b1100; p1_dir = 4'b0011; step_ready = 1'b1;
    do_reset;
    for (int k = 1; k <= 20; k++) begin
      step;
      tests++; if (step_valid !== 1'b0) begin fails++; $display("FAIL cancel_valid cyc %0d got %b exp 0", k, step_valid); end
    end
  endtask

  task automatic test_priority;
    logic ev;
    logic [3:0] e0;
`ifdef MOVE_SCHED_DIAGONAL_EN
    e0 = 4'b1010;
`else
    e0 = 4'b1000;
`endif
    p0_dir = 4'b1010; p1_dir = 4'b0111; step_ready = 1'b1;
    do_reset;
    for (int k = 1; k <= 12; k++) begin
      step;
      ev = (k == 9) || (k == 11);
      tests++; if (step_valid !== ev) begin fails++; $display("FAIL priority_valid cyc %0d got %b exp %b", k, step_valid, ev); end
      if (k == 9) begin
        tests++; if ({step_player, step_dir} !== {1'b0, e0}) begin fails++; $display("FAIL priority_p0 got %b/%b exp 0/%b", step_player, step_dir, e0); end
      end
      if (k == 11) begin
        tests++; if ({step_player, step_dir} !== 5'b1_0100) begin fails++; $display("FAIL priority_p1 got %b/%b exp 1/0100", step_player, step_dir); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [1:0] eo;
    p0_dir = 4'b1000; p1_dir = 4'b0001; step_ready = 1'b0;
    do_reset;
    for (int k = 1; k <= 20; k++) begin
      step;
      eo = (k >= 16) ? 2'b10 : 2'b00;
      tests++; if (step_valid !== (k >= 9)) begin fails++; $display("FAIL bp_valid cyc %0d got %b exp %b", k, step_valid, k >= 9); end
      if (k >= 9) begin
        tests++; if ({step_player, step_dir} !== 5'b0_1000) begin fails++; $display("FAIL bp_stable cyc %0d got %b/%b exp 0/1000", k, step_player, step_dir); end
      end
      tests++; if (overrun !== eo) begin fails++; $display("FAIL bp_overrun cyc %0d got %b exp %b", k, overrun, eo); end
    end
    step_ready = 1'b1;
    step;
    tests++; if (step_valid !== 1'b0) begin fails++; $display("FAIL bp_after_xfer got %b exp 0", step_valid); end
    step;
    tests++; if ({step_valid, step_player, step_dir} !== 6'b1_1_0001) begin fails++; $display("FAIL bp_p1_step got %b/%b/%b exp 1/1/0001", step_valid, step_player, step_dir); end
    ovr_clr = 1'b1;
    step;
    ovr_clr = 1'b0;
    tests++; if (overrun !== 2'b00) begin fails++; $display("FAIL bp_ovr_clr got %b exp 00", overrun); end
    step;
    tests++; if (overrun !== 2'b00) begin fails++; $display("FAIL bp_ovr_regrant got %b exp 00", overrun); end
    tests++; if ({step_valid, step_player, step_dir} !== 6'b1_0_1000) begin fails++; $display("FAIL bp_p0_step got %b/%b/%b exp 1/0/1000", step_valid, step_player, step_dir); end
  endtask

  task automatic test_reset_mid_offer;
    p0_dir = 4'b1000; p1_dir = 4'b0001; step_ready = 1'b0;
    do_reset;
    for (int k = 1; k <= 16; k++) step;
    tests++; if ({step_valid, overrun} !== 3'b1_10) begin fails++; $display("FAIL rmo_pre got %b/%b exp 1/10", step_valid, overrun); end
    rst = 1'b1;
    step;
    tests++; if ({step_valid, overrun} !== 3'b0_00) begin fails++; $display("FAIL rmo_reset got %b/%b exp 0/00", step_valid, overrun); end
    rst = 1'b0;
    step_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step;
      tests++; if (step_valid !== (k == 9)) begin fails++; $display("FAIL rmo_valid cyc %0d got %b exp %b", k, step_valid, k == 9); end
    end
    tests++; if ({step_player, step_dir} !== 5'b0_1000) begin fails++; $display("FAIL rmo_step got %b/%b exp 0/1000", step_player, step_dir); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_contention;
    test_cancel;
    test_priority;
    test_backpressure;
    test_reset_mid_offer;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
